mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the 8-bit-data / 7-bit-address en/w_en/r_en/ready/rdata memory bus.
// - Accepts one single-beat read or write request per transaction and stores data in a DEPTH x DATA_W array.
// - Inserts WAIT_CYC wait states, then pulses ready for one cycle; for reads, drives rdata in that same cycle.
// - Is the DUT the bus driver/monitor stimulate.
// PARAMETERS
// - ADDR_W    7             address width; DEPTH = 2**ADDR_W (128), so every address is valid
// - DATA_W    8             data width
// - WAIT_CYC  1             wait-state cycles between accept and response, range 0..15
// PORTS
// - clk    in   1        single clock, all logic on posedge
// - rst    in   1        asynchronous, active-low reset
// - en     in   1        request qualifier; w_en/r_en ignored when en=0
// - w_en   in   1        write request
// - r_en   in   1        read request
// - addr   in   ADDR_W   word address
// - wdata  in   DATA_W   write data
// - ready  out  1        one-cycle completion pulse
// - rdata  out  DATA_W   read data; holds last read value
// - err    out  1        collision flag (only with MEM_COLLISION_EN)
// BEHAVIOUR
// - Reset (rst=0, asynchronous): FSM=IDLE, ready=0, rdata=0, err=0, wait counter=0.
// - Reset also clears every array word to 0; an in-flight request is discarded and a pending write is not committed.
// - FSM states: IDLE, BUSY, RESP.
//   - IDLE: at a posedge with en & (w_en|r_en), latch addr, wdata and op.
//     - WAIT_CYC>0: go to BUSY and load counter = WAIT_CYC-1.
//     - WAIT_CYC=0: go straight to RESP.
//   - BUSY: decrement counter; go to RESP when counter==0. Occupies exactly WAIT_CYC cycles.
//   - RESP: ready=1 for exactly this one cycle, then unconditionally go to IDLE.
// - Latency: request sampled at edge N -> ready high in cycle starting at edge N+WAIT_CYC+1.
// - Write: array[addr_q] <= wdata_q at the edge entering RESP, so a read issued right after ready sees the new data.
// - Read: rdata <= array[addr_q] at the edge entering RESP. rdata holds until the next read completes or reset; writes do not change rdata.
// - Requests presented in BUSY/RESP are ignored (not queued).
//   - The bus driver holds the request until it samples ready, then drops or changes it.
//   - The cycle after RESP is IDLE and may accept a new request: one transaction per WAIT_CYC+2 cycles.
// - en=0: no request, regardless of w_en/r_en.
// - Latched addr/wdata are immune to input changes after accept.
// - Wait counter width: 4 bits, no wrap.
// CONFIGURATION
// - Macro MEM_COLLISION_EN.
// - Undefined: w_en & r_en together -> treated as write only; rdata unchanged. Port err does not exist.
// - Defined: port err exists. w_en & r_en together -> request still accepted and timed normally, but no array write and no rdata update; err=1 in the RESP cycle only. err=0 at all other times.
// TESTING
// - Reset: hold rst=0 3 cycles, release -> ready=0, rdata=0x00; read addr 0x10 -> rdata=0x00 with ready pulse.
// - Write/read, WAIT_CYC=1: write 0xA5 @0x05 at edge N -> ready=1 only in cycle N+2. Then read 0x05 -> rdata=0xA5 in ready cycle, held after.
// - Address extremes: write 0x11 @0x00, 0xEE @0x7F -> reads return 0x11 and 0xEE; no aliasing.
// - Ignored requests: en=0,w_en=1 @0x30 -> no ready, 0x30 stays 0x00. Write 0x44 @0x31 while BUSY -> no second ready, 0x31 stays 0x00.
// - Reset mid-op: write 0x3C @0x22, pull rst=0 during BUSY -> no ready pulse; after release, read 0x22 -> 0x00.
// - Collision (0x55 @0x40, w_en=r_en=1), and WAIT_CYC=0 latency (ready at edge N+1):
//   - without macro: read 0x40 -> 0x55;
//   - with MEM_COLLISION_EN: err=1 with ready, 0x40 stays 0x00, rdata unchanged.

Source files
------------

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Memory bus bundle for the single-beat en/w_en/r_en/ready/rdata protocol.
//   master : bus driver   -> drives en, w_en, r_en, addr, wdata
//                            samples ready, rdata (and err)
//   slave  : memory side  -> samples the request, drives ready, rdata (and err)
// Optional feature macro: MEM_COLLISION_EN adds the err collision flag.
// ---------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              en;
  logic              w_en;
  logic              r_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;
`ifdef MEM_COLLISION_EN
  logic              err;

  modport master (
    output en, w_en, r_en, addr, wdata,
    input  ready, rdata, err
  );

  modport slave (
    input  en, w_en, r_en, addr, wdata,
    output ready, rdata, err
  );
`else
  modport master (
    output en, w_en, r_en, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  en, w_en, r_en, addr, wdata,
    output ready, rdata
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the en/w_en/r_en/ready/rdata bus. Accepts one
// single-beat read or write at a time, inserts WAIT_CYC wait states, then
// pulses ready for one cycle (with rdata valid in that cycle for reads).
// Storage is a (2**ADDR_W) x DATA_W array cleared by reset.
//
// Ports
//   clk  : clock, all logic on posedge
//   rst  : asynchronous, active-low reset
//   bus  : mem_responder_if.slave
//            en/w_en/r_en/addr/wdata in, ready/rdata out, err out (optional)
//
// Parameters
//   ADDR_W   : address width, every address maps to a real word
//   DATA_W   : data width
//   WAIT_CYC : wait states between accept and response (0..15)
//
// Optional feature macro: MEM_COLLISION_EN
//   undefined : w_en & r_en together is a plain write
//   defined   : w_en & r_en together is timed normally but does nothing to
//               the array or rdata; err is raised in the response cycle
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter reload; BUSY runs for WAIT_CYC cycles ending on count 0.
  localparam int LOAD_I = (WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0;
  localparam logic [3:0] CNT_LOAD = LOAD_I[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Latched request
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              rd_q;

  // Live request decode
  logic              req;
  logic              req_wr;
  logic              req_rd;

  // Operation applied on the edge entering RESP
  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_wr;
  logic              cur_rd;

`ifdef MEM_COLLISION_EN
  logic              req_col;
  logic              col_q;
`endif

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  assign req = bus.en & (bus.w_en | bus.r_en);

`ifdef MEM_COLLISION_EN
  assign req_col = bus.w_en & bus.r_en;
  assign req_wr  = bus.w_en & ~bus.r_en;
  assign req_rd  = bus.r_en & ~bus.w_en;
`else
  // Simultaneous w_en/r_en degrades to a write.
  assign req_wr  = bus.w_en;
  assign req_rd  = bus.r_en & ~bus.w_en;
`endif

  // With WAIT_CYC=0 the commit edge is the accept edge itself, so the
  // latched copies are not yet valid; take the live request instead.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
      cur_wr    = req_wr;
      cur_rd    = req_rd;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_wr    = wr_q;
      cur_rd    = rd_q;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYC == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request capture; address/data are held stable by the op flags so they
  // need no reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else if (accept) begin
      wr_q <= req_wr;
      rd_q <= req_rd;
    end
  end

`ifdef MEM_COLLISION_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= 1'b0;
    end else if (accept) begin
      col_q <= req_col;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Storage array: cleared on reset so an aborted write never lands.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enter_resp && cur_wr) begin
      mem[cur_addr] <= cur_wdata;
    end
  end

  // Read data register holds the last completed read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (enter_resp && cur_rd) begin
      rdata_q <= mem[cur_addr];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ready = (state_q == RESP);
  assign bus.rdata = rdata_q;
`ifdef MEM_COLLISION_EN
  assign bus.err   = (state_q == RESP) & col_q;
`endif

endmodule
